// File: rtl/intr_pkg.sv
// Shared encodings for the interrupt controller: FSM states, register map, VEC layout.
// Latency: n/a (types and constants only). Backpressure: n/a.
// Imported by intr_ctrl and its bench.
package intr_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    SVC  = 2'd2
  } state_e;

  localparam logic [1:0] ADDR_PEND = 2'd0;
  localparam logic [1:0] ADDR_MASK = 2'd1;
  localparam logic [1:0] ADDR_VEC  = 2'd2;
  localparam logic [1:0] ADDR_EOI  = 2'd3;

  localparam int VEC_INSVC_BIT = 31;

endpackage

// File: rtl/intr_ctrl_if.sv
// CPU-facing bundle: IO register port plus the intr/int_ack handshake.
// Latency: n/a (wiring only). Backpressure: none, int_ack is a one-cycle pulse.
// master = CPU side, slave = controller side.
interface intr_ctrl_if;

  logic        io_cs;
  logic        io_rd;
  logic        io_wr;
  logic [1:0]  io_addr;
  logic [31:0] io_din;
  logic [31:0] io_dout;
  logic        intr;
  logic        int_ack;

  modport master (
    output io_cs, io_rd, io_wr, io_addr, io_din, int_ack,
    input  io_dout, intr
  );

  modport slave (
    input  io_cs, io_rd, io_wr, io_addr, io_din, int_ack,
    output io_dout, intr
  );

endinterface

// File: rtl/intr_prio_enc.sv
// Lowest-set-bit priority encoder: bit 0 of cand wins.
// Latency: combinational. Backpressure: none.
// sel is 0 when nothing is set; qualify it with any.
module intr_prio_enc #(
  parameter int N = 8,
  parameter int W = 3
) (
  input  logic [N-1:0] cand,
  output logic [W-1:0] sel,
  output logic         any
);

  always_comb begin
    sel = '0;
    any = |cand;
    // Scan high to low so the lowest set bit is the last to assign.
    for (int i = N - 1; i >= 0; i--) begin
      if (cand[i]) sel = W'(i);
    end
  end

endmodule

// File: rtl/intr_ctrl.sv
// Multi-source interrupt controller; INTR_LEVEL_EN selects level-sensitive sources.
// Latency: irq edge -> pending +1 cycle -> intr +2 cycles; EOI -> next intr 2 cycles.
// Backpressure: one request in flight; new edges accumulate in pending until EOI.
module intr_ctrl
  import intr_pkg::*;
#(
  parameter int N_SRC = 8,
  parameter int IDX_W = 3
) (
  input  logic             sys_clk,
  input  logic             reset,
  input  logic [N_SRC-1:0] irq_in,
  intr_ctrl_if.slave       bus
);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   cur_idx_q, cur_idx_d, sel;
  logic               in_svc_q, in_svc_d;
  logic               intr_q;
  logic               any;
  logic               ack_clr;
  logic               wr_en;
  logic [N_SRC-1:0]   pending, mask_q, cand;
  logic [31:0]        rdata;

  assign wr_en = bus.io_cs & bus.io_wr;
  assign cand  = pending & mask_q;

  intr_prio_enc #(.N(N_SRC), .W(IDX_W)) u_prio (
    .cand (cand),
    .sel  (sel),
    .any  (any)
  );

`ifdef INTR_LEVEL_EN
  // Live level inputs; the peripheral owns clearing its request.
  assign pending = irq_in;

  logic unused_level;
  assign unused_level = &{1'b0, ack_clr};
`else
  logic [N_SRC-1:0] irq_prev, pend_q, rise, pend_clr;

  assign rise = irq_in & ~irq_prev;

  always_comb begin
    pend_clr = '0;
    if (wr_en && bus.io_addr == ADDR_PEND) pend_clr = bus.io_din[N_SRC-1:0];
    if (ack_clr) pend_clr[cur_idx_q] = 1'b1;
  end

  // OR-ing rise after the clear lets a same-cycle edge win over W1C or ack.
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      irq_prev <= '0;
      pend_q   <= '0;
    end else begin
      irq_prev <= irq_in;
      pend_q   <= (pend_q & ~pend_clr) | rise;
    end
  end

  assign pending = pend_q;
`endif

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      mask_q <= '0;
    end else if (wr_en && bus.io_addr == ADDR_MASK) begin
      mask_q <= bus.io_din[N_SRC-1:0];
    end
  end

  always_comb begin
    state_d   = state_q;
    cur_idx_d = cur_idx_q;
    in_svc_d  = in_svc_q;
    ack_clr   = 1'b0;
    case (state_q)
      IDLE: begin
        if (any) begin
          cur_idx_d = sel;
          state_d   = REQ;
        end
      end
      REQ: begin
        if (bus.int_ack) begin
          ack_clr  = 1'b1;
          in_svc_d = 1'b1;
          state_d  = SVC;
        end else if (!cand[cur_idx_q]) begin
          state_d = IDLE;
        end
      end
      SVC: begin
        if (wr_en && bus.io_addr == ADDR_EOI) begin
          in_svc_d = 1'b0;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cur_idx_q <= '0;
      in_svc_q  <= 1'b0;
      intr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cur_idx_q <= cur_idx_d;
      in_svc_q  <= in_svc_d;
      intr_q    <= (state_d == REQ);
    end
  end

  assign bus.intr = intr_q;

  always_comb begin
    rdata = '0;
    if (bus.io_cs && bus.io_rd) begin
      case (bus.io_addr)
        ADDR_PEND: rdata[N_SRC-1:0] = pending;
        ADDR_MASK: rdata[N_SRC-1:0] = mask_q;
        ADDR_VEC: begin
          rdata[IDX_W-1:0]     = cur_idx_q;
          rdata[VEC_INSVC_BIT] = in_svc_q;
        end
        default: rdata = '0;
      endcase
    end
  end

  assign bus.io_dout = rdata;

  if (N_SRC < 32) begin : g_din_hi
    logic unused_din_hi;
    assign unused_din_hi = &{1'b0, bus.io_din[31:N_SRC]};
  end

endmodule

// File: tb/tb_intr_ctrl.sv
// Directed bench for intr_ctrl (edge-latched build); expectations queued, then popped at each check.
module tb_intr_ctrl;
  import intr_pkg::*;

  localparam int N_SRC = 8;
  localparam int IDX_W = 3;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  logic             sys_clk = 1'b0;
  logic             reset;
  logic [N_SRC-1:0] irq_in;
  intr_ctrl_if      bus ();

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  logic [31:0] d;

  intr_ctrl #(.N_SRC(N_SRC), .IDX_W(IDX_W)) dut (
    .sys_clk (sys_clk),
    .reset   (reset),
    .irq_in  (irq_in),
    .bus     (bus)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic tick();
    @(posedge sys_clk);
    @(negedge sys_clk);
  endtask

  task automatic expect_val(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic chk(input logic [31:0] obs);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty observed=%h", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val)
      else begin
        errors++;
        $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic chk_intr();
    chk({31'b0, bus.intr});
  endtask

  task automatic io_write(input logic [1:0] a, input logic [31:0] v);
    bus.io_cs   = 1'b1;
    bus.io_wr   = 1'b1;
    bus.io_addr = a;
    bus.io_din  = v;
    tick();
    bus.io_cs   = 1'b0;
    bus.io_wr   = 1'b0;
    bus.io_din  = '0;
  endtask

  task automatic io_read(input logic [1:0] a, output logic [31:0] v);
    bus.io_cs   = 1'b1;
    bus.io_rd   = 1'b1;
    bus.io_addr = a;
    #1;
    v = bus.io_dout;
    bus.io_cs   = 1'b0;
    bus.io_rd   = 1'b0;
  endtask

  task automatic ack_pulse();
    bus.int_ack = 1'b1;
    tick();
    bus.int_ack = 1'b0;
  endtask

  initial begin
    reset       = 1'b1;
    irq_in      = '0;
    bus.io_cs   = 1'b0;
    bus.io_rd   = 1'b0;
    bus.io_wr   = 1'b0;
    bus.io_addr = '0;
    bus.io_din  = '0;
    bus.int_ack = 1'b0;
    tick();
    tick();
    reset = 1'b0;

    // Reset state
    expect_val("rst_intr", 32'h0); chk_intr();
    expect_val("rst_mask", 32'h0); io_read(ADDR_MASK, d); chk(d);
    expect_val("rst_vec",  32'h0); io_read(ADDR_VEC, d);  chk(d);

    // Masked source latches but never interrupts; stray EOI is ignored
    irq_in = 8'h01;
    expect_val("masked_intr", 32'h0);
    tick(); irq_in = '0; tick(); tick();
    chk_intr();
    expect_val("masked_pend", 32'h1); io_read(ADDR_PEND, d); chk(d);
    io_write(ADDR_EOI, 32'h0);
    expect_val("eoi_idle_vec", 32'h0); io_read(ADDR_VEC, d); chk(d);
    io_write(ADDR_PEND, 32'hFF);
    expect_val("w1c_pend", 32'h0); io_read(ADDR_PEND, d); chk(d);

    // Basic flow on source 3
    io_write(ADDR_MASK, 32'hFF);
    expect_val("mask_rd", 32'hFF); io_read(ADDR_MASK, d); chk(d);
    irq_in = 8'h08;
    expect_val("basic_intr_k1", 32'h0);
    expect_val("basic_intr_k2", 32'h1);
    tick(); irq_in = '0; chk_intr();
    tick(); chk_intr();
    expect_val("basic_vec_req", 32'h3); io_read(ADDR_VEC, d); chk(d);
    ack_pulse();
    expect_val("basic_intr_ack", 32'h0); chk_intr();
    expect_val("basic_vec_svc", 32'h8000_0003); io_read(ADDR_VEC, d); chk(d);
    expect_val("basic_pend_ack", 32'h0); io_read(ADDR_PEND, d); chk(d);
    io_write(ADDR_EOI, 32'hDEAD_BEEF);
    expect_val("basic_vec_eoi", 32'h3); io_read(ADDR_VEC, d); chk(d);
    tick();
    expect_val("basic_intr_quiet", 32'h0); chk_intr();

    // Priority: 5 and 2 together, 2 first
    irq_in = 8'h24;
    tick(); irq_in = '0; tick();
    expect_val("prio_intr", 32'h1); chk_intr();
    expect_val("prio_vec_first", 32'h2); io_read(ADDR_VEC, d); chk(d);
    ack_pulse();
    expect_val("prio_vec_svc", 32'h8000_0002); io_read(ADDR_VEC, d); chk(d);
    expect_val("prio_pend_left", 32'h20); io_read(ADDR_PEND, d); chk(d);
    io_write(ADDR_EOI, 32'h0);
    expect_val("prio_intr_eoi1", 32'h0); chk_intr();
    tick();
    expect_val("prio_intr_eoi2", 32'h1); chk_intr();
    expect_val("prio_vec_second", 32'h5); io_read(ADDR_VEC, d); chk(d);
    ack_pulse();
    io_write(ADDR_EOI, 32'h0);
    expect_val("prio_pend_done", 32'h0); io_read(ADDR_PEND, d); chk(d);

    // Withdraw source 4 by masking it
    irq_in = 8'h10;
    tick(); irq_in = '0; tick();
    expect_val("wd_intr_req", 32'h1); chk_intr();
    io_write(ADDR_MASK, 32'hEF);
    tick();
    expect_val("wd_intr_drop", 32'h0); chk_intr();
    expect_val("wd_pend", 32'h10); io_read(ADDR_PEND, d); chk(d);
    expect_val("wd_vec", 32'h4); io_read(ADDR_VEC, d); chk(d);
    ack_pulse();
    expect_val("wd_ack_ignored", 32'h0); io_read(ADDR_VEC, d); chk({31'b0, d[31]});
    io_write(ADDR_PEND, 32'h10);

    // Collision: W1C and new rise on bit 1 in the same cycle
    io_write(ADDR_MASK, 32'h0);
    irq_in = 8'h02;
    tick(); irq_in = '0; tick();
    irq_in = 8'h02;
    io_write(ADDR_PEND, 32'h2);
    irq_in = '0;
    expect_val("coll_pend", 32'h2); io_read(ADDR_PEND, d); chk(d);
    io_write(ADDR_PEND, 32'h2);
    expect_val("coll_w1c", 32'h0); io_read(ADDR_PEND, d); chk(d);

    // Reset while in service
    io_write(ADDR_MASK, 32'hFF);
    irq_in = 8'h40;
    tick(); irq_in = '0; tick();
    ack_pulse();
    expect_val("svc_vec", 32'h8000_0006); io_read(ADDR_VEC, d); chk(d);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    expect_val("mid_rst_intr", 32'h0); chk_intr();
    expect_val("mid_rst_vec",  32'h0); io_read(ADDR_VEC, d);  chk(d);
    expect_val("mid_rst_mask", 32'h0); io_read(ADDR_MASK, d); chk(d);
    ack_pulse();
    expect_val("post_rst_ack_intr", 32'h0); chk_intr();
    expect_val("post_rst_ack_vec",  32'h0); io_read(ADDR_VEC, d); chk(d);

    checks++;
    assert (sb.size() == 0)
    else begin
      errors++;
      $error("FAIL scoreboard_leftover observed=%0d expected=0", sb.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
